// File: rtl/serializer_pkg.sv
// ============================================================================
//  Module      : serializer_pkg
//  Description : Shared state encoding, line levels and width helpers for the
//                serializer TX controller and its round-robin arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serializer_pkg;

  // Frame sequencing states; PARITY is only reachable in parity builds.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } state_t;

  // Line level while no frame is in progress (and during stop bits).
  localparam logic LINE_IDLE = 1'b1;

  // Width of a requester index; at least one bit even for a single requester.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of the per-bit clock counter.
  function automatic int clk_cnt_width(input int clks_per_bit);
    return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
  endfunction

  // Width of the bit counter; must hold DATA_WIDTH itself.
  function automatic int bit_cnt_width(input int data_width);
    return $clog2(data_width + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/serializer_tx_ctrl_rr_arbiter.sv
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin arbiter. Searches upward from
//                ptr+1 (modulo NUM_REQ) for the first asserted request.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
  import serializer_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int IW      = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_idx,
  output logic               any_valid
);

  logic          found;
  logic [IW-1:0] cand;
  int            cand_i;

  assign any_valid = |req;

  // Rotating priority search; the last-served index has lowest priority.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    cand_i    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_i = (int'(ptr) + k) % NUM_REQ;
      cand   = IW'(cand_i);
      if (en && !found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/serializer_tx_ctrl.sv
// ============================================================================
//  Module      : serializer_tx_ctrl
//  Description : Arbitrates NUM_REQ word requesters, loads the granted word
//                into the PISO serializer, steps it one bit per CLKS_PER_BIT
//                clocks and frames the stream with start/stop bits.
//                Optional macro SERIALIZER_TX_PARITY_EN inserts an even-parity
//                bit between the data bits and the stop bit(s).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serializer_tx_ctrl
  import serializer_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_REQ      = 2,
  parameter int CLKS_PER_BIT = 4,
  parameter int STOP_BITS    = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          ser_load,
  output logic [DATA_WIDTH-1:0]         ser_data,
  output logic                          ser_shift,
  input  logic                          ser_srl,
  output logic                          tx_line,
  output logic                          tx_active,
  output logic [id_width(NUM_REQ)-1:0]  grant_id
);

  localparam int IW = id_width(NUM_REQ);
  localparam int CW = clk_cnt_width(CLKS_PER_BIT);
  localparam int BW = bit_cnt_width(DATA_WIDTH);

  localparam logic [CW-1:0] CLK_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CLK_SHIFT  = CW'(CLKS_PER_BIT - 2);
  localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] STOP_LAST  = BW'(STOP_BITS - 1);
  localparam logic [IW-1:0] PTR_RESET  = IW'(NUM_REQ - 1);

  state_t                state, state_n;
  logic [CW-1:0]         clk_cnt, clk_cnt_n;
  logic [BW-1:0]         bit_cnt, bit_cnt_n;
  logic [IW-1:0]         ptr, ptr_n;
  logic [NUM_REQ-1:0]    ready_n;
  logic                  load_n, shift_n, active_n;
  logic [DATA_WIDTH-1:0] data_n;
  logic [IW-1:0]         gid_n;

  logic [NUM_REQ-1:0]    arb_grant;
  logic [IW-1:0]         arb_idx;
  logic                  arb_any;
  logic                  period_end;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr),
    .en        (state == IDLE),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_valid (arb_any)
  );

  assign period_end = (clk_cnt == CLK_LAST);

  // Registers: FSM state, counters, RR pointer and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      clk_cnt   <= '0;
      bit_cnt   <= '0;
      ptr       <= PTR_RESET;
      req_ready <= '0;
      ser_load  <= 1'b0;
      ser_data  <= '0;
      ser_shift <= 1'b0;
      tx_active <= 1'b0;
      grant_id  <= '0;
    end else begin
      state     <= state_n;
      clk_cnt   <= clk_cnt_n;
      bit_cnt   <= bit_cnt_n;
      ptr       <= ptr_n;
      req_ready <= ready_n;
      ser_load  <= load_n;
      ser_data  <= data_n;
      ser_shift <= shift_n;
      tx_active <= active_n;
      grant_id  <= gid_n;
    end
  end

  // Next-state, counter and output-strobe decode.
  always_comb begin
    state_n   = state;
    clk_cnt_n = period_end ? '0 : clk_cnt + 1'b1;
    bit_cnt_n = bit_cnt;
    ptr_n     = ptr;
    ready_n   = '0;
    load_n    = 1'b0;
    shift_n   = 1'b0;
    data_n    = ser_data;
    active_n  = tx_active;
    gid_n     = grant_id;
    case (state)
      IDLE: begin
        clk_cnt_n = '0;
        if (arb_any) begin
          ready_n  = arb_grant;
          load_n   = 1'b1;
          data_n   = req_data[arb_idx*DATA_WIDTH +: DATA_WIDTH];
          gid_n    = arb_idx;
          ptr_n    = arb_idx;
          active_n = 1'b1;
          state_n  = START;
        end
      end
      START: begin
        if (period_end) begin
          state_n   = DATA;
          bit_cnt_n = '0;
        end
      end
      DATA: begin
        // Registered strobe: set one cycle early so it lands on the period's last cycle.
        shift_n = (clk_cnt == CLK_SHIFT);
        if (period_end) begin
          bit_cnt_n = bit_cnt + 1'b1;
          if (bit_cnt == BIT_LAST) begin
            bit_cnt_n = '0;
`ifdef SERIALIZER_TX_PARITY_EN
            state_n   = PARITY;
`else
            state_n   = STOP;
`endif
          end
        end
      end
      PARITY: begin
        if (period_end) begin
          state_n   = STOP;
          bit_cnt_n = '0;
        end
      end
      STOP: begin
        // bit_cnt counts stop-bit periods here.
        if (period_end) begin
          if (bit_cnt == STOP_LAST) begin
            state_n   = IDLE;
            active_n  = 1'b0;
            bit_cnt_n = '0;
          end else begin
            bit_cnt_n = bit_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Line mux: only the data phase passes the serializer output through.
  always_comb begin
    tx_line = LINE_IDLE;
    case (state)
      START:   tx_line = 1'b0;
      DATA:    tx_line = ser_srl;
`ifdef SERIALIZER_TX_PARITY_EN
      PARITY:  tx_line = ^ser_data;
`endif
      default: tx_line = LINE_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_serializer_tx_ctrl.sv
// ============================================================================
//  Module      : tb_serializer_tx_ctrl
//  Description : Directed self-checking bench for serializer_tx_ctrl with a
//                behavioural PISO model on each instance. Instance u_dut uses
//                one stop bit, u_dut2 uses two.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serializer_tx_ctrl;

`ifdef SERIALIZER_TX_PARITY_EN
  localparam int PAR = 4;
`else
  localparam int PAR = 0;
`endif
  localparam int FL  = 40 + PAR;   // frame length, one stop bit
  localparam int GAP = FL + 1;     // load-to-load spacing back to back

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [15:0] req_data  = '0;
  logic [1:0]  req_ready;
  logic        ser_load, ser_shift, ser_srl, tx_line, tx_active;
  logic [7:0]  ser_data;
  logic [0:0]  grant_id;

  logic [1:0]  valid2 = '0;
  logic [15:0] data2  = '0;
  logic [1:0]  ready2;
  logic        load2, shift2, srl2, line2, active2;
  logic [7:0]  sdata2;
  logic [0:0]  gid2;

  logic [7:0]  sreg, sreg2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serializer_tx_ctrl #(.DATA_WIDTH(8), .NUM_REQ(2), .CLKS_PER_BIT(4), .STOP_BITS(1)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .ser_load(ser_load), .ser_data(ser_data), .ser_shift(ser_shift), .ser_srl(ser_srl),
    .tx_line(tx_line), .tx_active(tx_active), .grant_id(grant_id));

  serializer_tx_ctrl #(.DATA_WIDTH(8), .NUM_REQ(2), .CLKS_PER_BIT(4), .STOP_BITS(2)) u_dut2 (
    .clk(clk), .rst(rst), .req_valid(valid2), .req_data(data2), .req_ready(ready2),
    .ser_load(load2), .ser_data(sdata2), .ser_shift(shift2), .ser_srl(srl2),
    .tx_line(line2), .tx_active(active2), .grant_id(gid2));

  // PISO serializer models, LSB first.
  always @(posedge clk) begin
    if (rst)            sreg <= '0;
    else if (ser_load)  sreg <= ser_data;
    else if (ser_shift) sreg <= sreg >> 1;
  end
  assign ser_srl = sreg[0];

  always @(posedge clk) begin
    if (rst)         sreg2 <= '0;
    else if (load2)  sreg2 <= sdata2;
    else if (shift2) sreg2 <= sreg2 >> 1;
  end
  assign srl2 = sreg2[0];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected line trace for one frame starting at sample 0 (first START cycle).
  function automatic logic [63:0] exp_trace(input logic [7:0] w, input int n);
    logic [63:0] t;
    t = '1;
    for (int i = 0; i < 64; i++) begin
      if (i >= n)             t[i] = 1'b0;
      else if (i < 4)         t[i] = 1'b0;
      else if (i < 36)        t[i] = w[(i - 4) / 4];
      else if (i < 36 + PAR)  t[i] = ^w;
      else                    t[i] = 1'b1;
    end
    return t;
  endfunction

  // Capture results
  logic [63:0] trace;
  int n_shift, n_active, n_active2, n_ready, ready_bad, n_load;
  int load_cyc[$];
  int load_gid[$];
  int load_dat[$];
  logic auto_drop;

  function automatic int qc(input int k);
    return (load_cyc.size() > k) ? load_cyc[k] : -1;
  endfunction
  function automatic int qg(input int k);
    return (load_gid.size() > k) ? load_gid[k] : -1;
  endfunction
  function automatic int qd(input int k);
    return (load_dat.size() > k) ? load_dat[k] : -1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0;
    valid2 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic capture(input int n, input int late_at, input logic [1:0] late_mask);
    logic [1:0] prev_r, prev_r2;
    prev_r = '0; prev_r2 = '0;
    trace = '0;
    n_shift = 0; n_active = 0; n_active2 = 0; n_ready = 0; ready_bad = 0; n_load = 0;
    load_cyc.delete(); load_gid.delete(); load_dat.delete();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i < 64) trace[i] = tx_line;
      if (ser_shift) n_shift++;
      if (tx_active) n_active++;
      if (active2)   n_active2++;
      if (req_ready != 2'b00) begin
        n_ready++;
        if (req_ready != (2'b01 << grant_id)) ready_bad++;
      end
      if (ser_load) begin
        n_load++;
        load_cyc.push_back(i);
        load_gid.push_back(int'(grant_id));
        load_dat.push_back(int'(ser_data));
      end
      if (auto_drop) begin
        req_valid = req_valid & ~prev_r;
        valid2    = valid2 & ~prev_r2;
      end
      prev_r  = req_ready;
      prev_r2 = ready2;
      if (i == late_at) req_valid = req_valid | late_mask;
    end
  endtask

  task automatic single_frame(input logic [7:0] w);
    do_reset();
    req_data  = {8'h00, w};
    req_valid = 2'b01;
    data2     = {8'h00, w};
    valid2    = 2'b01;
    auto_drop = 1'b1;
    capture(48 + PAR, -1, 2'b00);
    check_eq("sf_loads",   n_load, 1);
    check_eq("sf_load_t0", qc(0), 0);
    check_eq("sf_data",    qd(0), int'(w));
    check_eq("sf_gid",     qg(0), 0);
    check_eq("sf_readys",  n_ready, 1);
    check_eq("sf_trace",   trace, exp_trace(w, 48 + PAR));
    check_eq("sf_shifts",  n_shift, 8);
    check_eq("sf_active",  n_active, FL);
    check_eq("sf_active_stop2", n_active2, FL + 4);
  endtask

  initial begin
    auto_drop = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_ready",  req_ready, 0);
    check_eq("rst_load",   ser_load, 0);
    check_eq("rst_shift",  ser_shift, 0);
    check_eq("rst_data",   ser_data, 0);
    check_eq("rst_active", tx_active, 0);
    check_eq("rst_gid",    grant_id, 0);
    check_eq("rst_line",   tx_line, 1);
    check_eq("rst_line2",  line2, 1);

    // Single frame 0xA5
    single_frame(8'hA5);

`ifdef SERIALIZER_TX_PARITY_EN
    single_frame(8'h07);
    check_eq("par_07", trace[36], 1'b1);
    single_frame(8'h03);
    check_eq("par_03", trace[36], 1'b0);
`endif

    // Back-to-back round robin, both requesters always valid
    do_reset();
    req_data  = {8'h66, 8'h99};
    req_valid = 2'b11;
    auto_drop = 1'b0;
    capture(3 * GAP + 2, -1, 2'b00);
    req_valid = 2'b00;
    check_eq("rr_loads",  n_load, 4);
    check_eq("rr_gids",   {qg(3) == 1, qg(2) == 1, qg(1) == 1, qg(0) == 1}, 4'b1010);
    check_eq("rr_t1",     qc(1), GAP);
    check_eq("rr_t2",     qc(2), 2 * GAP);
    check_eq("rr_t3",     qc(3), 3 * GAP);
    check_eq("rr_readys", n_ready, 4);
    check_eq("rr_ready_onehot", ready_bad, 0);
    check_eq("rr_data1",  qd(1), 8'h66);

    // Late request during DATA waits for IDLE
    do_reset();
    req_data  = {8'h3C, 8'hC3};
    req_valid = 2'b01;
    auto_drop = 1'b1;
    capture(GAP + FL + 4, 10, 2'b10);
    check_eq("late_loads",  n_load, 2);
    check_eq("late_t1",     qc(1), GAP);
    check_eq("late_gid1",   qg(1), 1);
    check_eq("late_data1",  qd(1), 8'h3C);
    check_eq("late_readys", n_ready, 2);
    check_eq("late_active", n_active, 2 * FL);
    check_eq("late_gid_hold", grant_id, 1);
    check_eq("late_idle_line", tx_line, 1);

    // Reset in the middle of DATA, then pointer must be back at reset value
    do_reset();
    req_data  = {8'h22, 8'h11};
    req_valid = 2'b01;
    auto_drop = 1'b1;
    capture(14, -1, 2'b00);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_line",   tx_line, 1);
    check_eq("mid_rst_active", tx_active, 0);
    check_eq("mid_rst_ready",  req_ready, 0);
    rst = 1'b0;
    req_valid = 2'b11;
    auto_drop = 1'b0;
    capture(1, -1, 2'b00);
    req_valid = 2'b00;
    check_eq("mid_rst_gid",  qg(0), 0);
    check_eq("mid_rst_data", qd(0), 8'h11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
